// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit (NOT/AND/OR/XOR)
// among N_REQ requesters; each grant performs one operation and tags it with the requester index.
module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [N_REQ-1:0]           req,
    input  logic [2*N_REQ-1:0]         op,
    input  logic [WIDTH*N_REQ-1:0]     a,
    input  logic [WIDTH*N_REQ-1:0]     b,
    output logic [N_REQ-1:0]           gnt,
    output logic                       y_valid,
    output logic [WIDTH-1:0]           y,
    output logic [$clog2(N_REQ)-1:0]   y_id,
    output logic [CNT_W-1:0]           ops_done
);

    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_next;
    logic [ID_W-1:0]  sel;
    logic [ID_W-1:0]  idx;
    logic [N_REQ-1:0] eligible;
    logic             found;
    logic             grant_ok;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] y_next;

    // Masking the current grant keeps one level request from being served twice.
    always_comb begin
        eligible = req & ~gnt;
        found    = 1'b0;
        sel      = '0;
        idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign grant_ok = en && found;
    assign ptr_next = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + ID_W'(1);

    always_comb begin
        op_sel = op[int'(sel)*2 +: 2];
        a_sel  = a[int'(sel)*WIDTH +: WIDTH];
        b_sel  = b[int'(sel)*WIDTH +: WIDTH];
        unique case (op_sel)
            2'b00:   y_next = ~a_sel;
            2'b01:   y_next = a_sel & b_sel;
            2'b10:   y_next = a_sel | b_sel;
            default: y_next = a_sel ^ b_sel;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt      <= '0;
            y_valid  <= 1'b0;
            y        <= '0;
            y_id     <= '0;
            ptr      <= '0;
            ops_done <= '0;
        end else if (grant_ok) begin
            gnt      <= N_REQ'(1) << sel;
            y_valid  <= 1'b1;
            y        <= y_next;
            y_id     <= sel;
            ptr      <= ptr_next;
            ops_done <= ops_done + CNT_W'(1);
        end else begin
            gnt     <= '0;
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: reset, opcodes, rotation, masking, enable,
// mid-grant reset and counter wrap (second instance with a 4-bit counter).
module tb_logic_unit_arbiter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    logic [3:0]  gnt;
    logic        y_valid;
    logic [7:0]  y;
    logic [1:0]  y_id;
    logic [15:0] ops_done;

    logic [3:0]  gnt_w;
    logic        y_valid_w;
    logic [7:0]  y_w;
    logic [1:0]  y_id_w;
    logic [3:0]  ops_done_w;

    int checks;
    int failures;

    logic [7:0] exp_y [4];

    logic_unit_arbiter #(.N_REQ(4), .WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .op(op), .a(a), .b(b),
        .gnt(gnt), .y_valid(y_valid), .y(y), .y_id(y_id), .ops_done(ops_done)
    );

    logic_unit_arbiter #(.N_REQ(4), .WIDTH(8), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .op(op), .a(a), .b(b),
        .gnt(gnt_w), .y_valid(y_valid_w), .y(y_w), .y_id(y_id_w), .ops_done(ops_done_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_rr_vectors();
        op = 8'hE4;
        a  = 32'hC355F03C;
        b  = 32'hFF0F3C00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0]  op_codes [4];
        logic [7:0]  single_y [4];
        checks   = 0;
        failures = 0;
        exp_y[0] = 8'hC3;
        exp_y[1] = 8'h30;
        exp_y[2] = 8'h5F;
        exp_y[3] = 8'h3C;
        op_codes[0] = 8'h00; op_codes[1] = 8'h01; op_codes[2] = 8'h02; op_codes[3] = 8'h03;
        single_y[0] = 8'h5A; single_y[1] = 8'h05; single_y[2] = 8'hAF; single_y[3] = 8'hAA;

        en    = 1'b1;
        req   = 4'hF;
        rst_n = 1'b0;
        set_rr_vectors();

        // reset held for two edges with all requests high
        tick();
        tick();
        check("rst_gnt",      32'(gnt),      32'h0);
        check("rst_y_valid",  32'(y_valid),  32'h0);
        check("rst_y",        32'(y),        32'h0);
        check("rst_y_id",     32'(y_id),     32'h0);
        check("rst_ops_done", 32'(ops_done), 32'h0);
        rst_n = 1'b1;
        tick();
        check("first_gnt",  32'(gnt),  32'h1);
        check("first_y_id", 32'(y_id), 32'h0);
        check("first_y",    32'(y),    32'hC3);
        req = 4'h0;
        tick();
        check("idle_gnt",     32'(gnt),     32'h0);
        check("idle_y_valid", 32'(y_valid), 32'h0);
        check("idle_y_hold",  32'(y),       32'hC3);

        // single requester 2, each opcode
        for (int i = 0; i < 4; i++) begin
            a[23:16] = 8'hA5;
            b[23:16] = 8'h0F;
            op[5:4]  = op_codes[i][1:0];
            req      = 4'b0100;
            tick();
            check("op_gnt",     32'(gnt),     32'h4);
            check("op_y_id",    32'(y_id),    32'h2);
            check("op_y",       32'(y),       32'(single_y[i]));
            check("op_y_valid", 32'(y_valid), 32'h1);
            req = 4'h0;
            tick();
            check("op_drop_gnt", 32'(gnt), 32'h0);
        end
        check("op_ops_done", 32'(ops_done), 32'h5);

        // strict rotation with all four requesting
        set_rr_vectors();
        do_reset();
        req = 4'hF;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr_gnt",  32'(gnt),  32'(4'b0001 << (i % 4)));
            check("rr_y_id", 32'(y_id), 32'(i % 4));
            check("rr_y",    32'(y),    32'(exp_y[i % 4]));
        end
        check("rr_ops_done", 32'(ops_done), 32'h8);
        req = 4'h0;
        tick();

        // lone requester: granted every other cycle
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("lone_y_valid", 32'(y_valid), (i % 2 == 0) ? 32'h1 : 32'h0);
            check("lone_gnt",     32'(gnt),     (i % 2 == 0) ? 32'h2 : 32'h0);
        end
        check("lone_y",        32'(y),        32'h30);
        check("lone_ops_done", 32'(ops_done), 32'h3);
        req = 4'h0;
        tick();

        // enable dropped during the grant to requester 1
        do_reset();
        req = 4'hF;
        tick();
        check("en_gnt0", 32'(gnt), 32'h1);
        tick();
        check("en_gnt1", 32'(gnt), 32'h2);
        en = 1'b0;
        #2;
        check("en_complete_valid", 32'(y_valid), 32'h1);
        check("en_complete_y",     32'(y),       32'h30);
        tick();
        check("en_off_gnt",  32'(gnt),  32'h0);
        check("en_off_y_id", 32'(y_id), 32'h1);
        tick();
        check("en_off_gnt2", 32'(gnt),      32'h0);
        check("en_off_cnt",  32'(ops_done), 32'h2);
        en = 1'b1;
        tick();
        check("en_resume_gnt", 32'(gnt), 32'h4);

        // reset asserted during a grant cycle overrides the next selection
        rst_n = 1'b0;
        tick();
        check("mid_rst_gnt",      32'(gnt),      32'h0);
        check("mid_rst_y_valid",  32'(y_valid),  32'h0);
        check("mid_rst_y",        32'(y),        32'h0);
        check("mid_rst_y_id",     32'(y_id),     32'h0);
        check("mid_rst_ops_done", 32'(ops_done), 32'h0);
        rst_n = 1'b1;
        tick();
        check("mid_rst_ptr0", 32'(gnt), 32'h1);

        // counter wrap on the 4-bit instance
        do_reset();
        req = 4'hF;
        for (int i = 0; i < 17; i++) tick();
        check("wrap_ops_done_w", 32'(ops_done_w), 32'h1);
        check("wrap_ops_done",   32'(ops_done),   32'd17);
        check("wrap_gnt_w",      32'(gnt_w),      32'h1);
        req = 4'h0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one registered bitwise logic unit (NOT / AND / OR / XOR) among N_REQ requesters. It is the first shared-resource block in the logic-gate library. It sits between several client blocks and a single gate datapath of width WIDTH. Each grant performs exactly one operation for one requester and returns the result with its requester ID.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset (sampled on rising clk edge)
- en  in  1  arbitration enable; 0 = no new grants
- req  in  N_REQ  per-requester level request
- op  in  2*N_REQ  per-requester opcode, requester i at [2i+1:2i]
- a  in  WIDTH*N_REQ  operand A, requester i at [WIDTH*i +: WIDTH]
- b  in  WIDTH*N_REQ  operand B, same packing; ignored for NOT
- gnt  out  N_REQ  registered one-hot grant (all-zero when none)
- y_valid  out  1  result valid, high exactly when gnt != 0
- y  out  WIDTH  registered result
- y_id  out  $clog2(N_REQ)  index of granted requester
- ops_done  out  CNT_W  count of completed operations, wraps

## Operation
- Opcodes: 00 = ~a, 01 = a&b, 10 = a|b, 11 = a^b; bitwise over WIDTH.
- Internal state: round-robin pointer ptr (0..N_REQ-1), registered gnt/y/y_id/y_valid, ops_done.
- Eligible set on each edge: req & ~gnt. The requester granted in the current cycle is masked, so one level request is never consumed twice.
- Selection when en=1 and eligible != 0: the first eligible index searching ptr, ptr+1, … modulo N_REQ.
  - On that edge: gnt <= one-hot(sel), y_id <= sel, y <= f(op[sel], a[sel], b[sel]), y_valid <= 1.
  - ptr <= (sel+1) mod N_REQ.
  - ops_done <= ops_done+1.
- When en=0 or the eligible set is empty: gnt <= 0, y_valid <= 0; y and y_id hold; ptr and ops_done hold.
- Requester contract:
  - Keep req, op, a and b stable from req rise until gnt is seen high.
  - At the edge ending the gnt cycle, either drop req or present new op/a/b to request again.
- ops_done wraps from 2^CNT_W-1 to 0 with no flag.
- Reset (rst_n=0 at an edge): gnt=0, y_valid=0, y=0, y_id=0, ptr=0, ops_done=0.
  - This overrides any selection on that edge. A mid-operation grant is dropped; no partial result.
- en falling during a gnt cycle: the current result completes normally; no further grants.

## Timing
- Latency: req sampled at edge k gives gnt/y_valid/y valid during cycle k..k+1 (one cycle, registered). There is no combinational input-to-output path.
- Throughput: one operation per cycle when ≥2 requesters are active.
- A lone continuously-requesting requester is granted every other cycle (masking).
- Fairness: with all N_REQ requesting, each is granted once per N_REQ grants (strict rotation).
- Outputs are fully registered; y holds its last value while y_valid=0.

## Test plan
- Reset: drive rst_n=0 for 2 edges with all req=1 -> gnt=0, y_valid=0, y=0, y_id=0, ops_done=0. First grant after release goes to requester 0.
- Single op per opcode: req[2] only, a=8'hA5, b=8'h0F, op in turn 00/01/10/11.
  - Required results: y=8'h5A / 8'h05 / 8'hAF / 8'hAA, each with y_id=2 and gnt=4'b0100 one cycle after request.
- Round-robin: all four req held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3, back to back; ops_done=8.
- Lone requester held high: req[1]=1 for 6 cycles -> gnt[1] high on alternate cycles (3 grants), y_valid pattern 1,0,1,0,1,0.
- en and reset mid-stream: all req high, drop en after grant to requester 1.
  - Required: that result completes; no gnt while en=0; next grant after en=1 is requester 2.
  - Assert rst_n=0 in the same cycle as a grant -> outputs cleared on that edge; ptr=0.
- Counter wrap: CNT_W=4, 17 grants -> ops_done reads 1.
